computational_unit_mc: RTL and testbench
========================================

// Module: computational_unit_mc
// PURPOSE
//  Parametrised next-generation datapath for the nibble CPU. Holds the x0/x1/y0/y1/r/m/i/o_reg
//  register set, the data_bus source mux and the ALU, with data width DW instead of fixed 4.
//  Adds an iterative multi-cycle shift-add multiplier with a busy stall output and a carry/borrow flag.
//  Sits between the program sequencer (controls, ir_nibble) and data memory/IO pins.
// PARAMETERS
//  DW  4  data width of every register, data_bus, i_pins, dm and ALU operand
// PORTS
//  clk         in   1     single system clock, all state updates on posedge
//  sync_reset  in   1     synchronous, active-high reset
//  i_pins      in   DW    input port value, source 9
//  dm          in   DW    data memory read value, source 7
//  ir_nibble   in   4     [2:0] ALU function, [3] modifier; zero-extended to DW as pm_data, source 8
//  source_sel  in   4     data_bus source select
//  reg_en      in   9     write enables: 0 x0, 1 x1, 2 y0, 3 y1, 4 r/flags, 5 m, 6 i, 8 o_reg (7 unused)
//  i_sel       in   1     0: i<=data_bus, 1: i<=i+m
//  x_sel       in   1     ALU x operand: 0 x0, 1 x1
//  y_sel       in   1     ALU y operand: 0 y0, 1 y1
//  data_bus    out  DW    selected source (combinational)
//  x0,x1,y0,y1,r,m,i,o_reg  out DW  architectural registers
//  r_eq_0      out  1     registered: r written value == 0
//  r_carry     out  1     registered: carry of add / borrow of sub, else 0
//  busy        out  1     multiplier in progress; sequencer must stall
//  from_CU     out  2*DW  {x1,x0}
// BEHAVIOUR
//  Reset: all DW regs <=0, r_eq_0<=1, r_carry<=0, busy<=0, FSM<=IDLE; overrides all enables and
//   aborts an in-flight multiply (no r write).
//  data_bus: 0 x0,1 x1,2 y0,3 y1,4 r,5 m,6 i,7 dm,8 pm_data,9 i_pins,10..15 -> 0.
//  x0..y1, m, o_reg: reg <= data_bus when enable set, else hold. Writes allowed while busy.
//  i: enable set -> i_sel?(i+m mod 2^DW):data_bus.
//  Single-cycle ALU (1-cycle latency into r when reg_en[4]=1 and busy=0):
//   000: ir[3]=0 -x (two's complement), ir[3]=1 r (hold/NOP); 001 x-y; 010 x+y;
//   101 x^y; 110 x&y; 111: ir[3]=0 ~x, ir[3]=1 r. Results mod 2^DW.
//   r_carry<=carry-out for 010, borrow (x<y unsigned) for 001, 0 for all others.
//   r_eq_0<=(result==0) on every r write.
//  Multiply 011 (high half) / 100 (low half), unsigned DW x DW -> 2*DW:
//   FSM IDLE->MUL->IDLE. Issue in IDLE when reg_en[4]=1: latch x, y, half-select; counter<=0;
//   product acc<=0; busy<=1 from next cycle.
//   MUL: one shift-add step per cycle, DW steps total; busy=1 for exactly DW cycles.
//   On edge ending step DW: r<=selected half, r_eq_0<=(half==0), r_carry<=0, busy<=0, ->IDLE.
//   Operands latched at issue: later x/y writes do not affect result.
//   reg_en[4]=1 while busy: ignored (no r write, no new issue). Issue on the cycle busy falls
//   is accepted only after busy=0 is visible (i.e. the following cycle).
//  from_CU = {x1,x0} combinational.
// TESTING (DW=4)
//  Reset: hold sync_reset 1 cycle mid-multiply -> all regs 0, r_eq_0=1, busy=0, r unchanged-from-0.
//  Load x0=9,y0=8 via source 8; op 010 -> r=1, r_carry=1, r_eq_0=0; op 001 with x0=3,y0=5 -> r=14, r_carry=1.
//  x0=13,y0=11, op 100, reg_en[4]=1: busy high 4 cycles, then r=15 (143=0x8F); repeat op 011 -> r=8.
//  During multiply write x0=0 and pulse reg_en[4] with op 010 -> result unaffected, r written only at end.
//  m=3,i=14, i_sel=1, reg_en[6]=1 -> i=1 (wrap); source_sel 12 -> data_bus=0.
//  op 000 ir[3]=1 after r=5 -> r stays 5, r_eq_0=0; x0=0 op 000 ir[3]=0 -> r=0, r_eq_0=1.

Source files
------------

// File: rtl/computational_unit_mc_if.sv
// rtl/computational_unit_mc_if.sv - sequencer/memory-side bundle of the nibble CPU datapath
interface computational_unit_mc_if #(parameter int DW = 4);
    logic [DW-1:0]   i_pins;
    logic [DW-1:0]   dm;
    logic [3:0]      ir_nibble;
    logic [3:0]      source_sel;
    logic [8:0]      reg_en;
    logic            i_sel;
    logic            x_sel;
    logic            y_sel;
    logic [DW-1:0]   data_bus;
    logic [DW-1:0]   x0;
    logic [DW-1:0]   x1;
    logic [DW-1:0]   y0;
    logic [DW-1:0]   y1;
    logic [DW-1:0]   r;
    logic [DW-1:0]   m;
    logic [DW-1:0]   i;
    logic [DW-1:0]   o_reg;
    logic            r_eq_0;
    logic            r_carry;
    logic            busy;
    logic [2*DW-1:0] from_CU;

    modport master (
        output i_pins, dm, ir_nibble, source_sel, reg_en, i_sel, x_sel, y_sel,
        input  data_bus, x0, x1, y0, y1, r, m, i, o_reg, r_eq_0, r_carry, busy, from_CU
    );

    modport slave (
        input  i_pins, dm, ir_nibble, source_sel, reg_en, i_sel, x_sel, y_sel,
        output data_bus, x0, x1, y0, y1, r, m, i, o_reg, r_eq_0, r_carry, busy, from_CU
    );
endinterface

// File: rtl/computational_unit_mc.sv
// rtl/computational_unit_mc.sv - DW-wide register file, source mux, ALU and shift-add multiplier
module computational_unit_mc #(
    parameter int DW = 4
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    computational_unit_mc_if.slave bus
);
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_x0, r_x1, r_y0, r_y1, r_r, r_m, r_i, r_o_reg;
    logic            r_z_flag;
    logic            r_c_flag;
    logic [2*DW-1:0] r_mul_x;
    logic [DW-1:0]   r_mul_y;
    logic [2*DW-1:0] r_acc;
    logic            r_hi_sel;
    logic [CW-1:0]   r_cnt;

    logic [DW-1:0]   w_pm_data;
    logic [DW-1:0]   w_data_bus;
    logic [DW-1:0]   w_x;
    logic [DW-1:0]   w_y;
    logic [2:0]      w_op;
    logic            w_mod;
    logic            w_is_mul;
    logic [DW:0]     w_sum;
    logic [DW:0]     w_diff;
    logic [DW-1:0]   w_alu_res;
    logic            w_alu_c;
    logic            w_issue;
    logic            w_alu_wr;
    logic            w_mul_done;
    logic [2*DW-1:0] w_acc_next;
    logic [DW-1:0]   w_half;
    logic            w_unused_reg_en7;

    assign w_unused_reg_en7 = bus.reg_en[7];
    assign w_pm_data = DW'(bus.ir_nibble);
    assign w_op      = bus.ir_nibble[2:0];
    assign w_mod     = bus.ir_nibble[3];
    assign w_is_mul  = (w_op == 3'b011) || (w_op == 3'b100);
    assign w_x       = bus.x_sel ? r_x1 : r_x0;
    assign w_y       = bus.y_sel ? r_y1 : r_y0;

    always_comb begin
        w_data_bus = '0;
        case (bus.source_sel)
            4'd0:    w_data_bus = r_x0;
            4'd1:    w_data_bus = r_x1;
            4'd2:    w_data_bus = r_y0;
            4'd3:    w_data_bus = r_y1;
            4'd4:    w_data_bus = r_r;
            4'd5:    w_data_bus = r_m;
            4'd6:    w_data_bus = r_i;
            4'd7:    w_data_bus = bus.dm;
            4'd8:    w_data_bus = w_pm_data;
            4'd9:    w_data_bus = bus.i_pins;
            default: w_data_bus = '0;
        endcase
    end

    // Borrow falls out as the top bit of the zero-extended difference.
    assign w_sum  = {1'b0, w_x} + {1'b0, w_y};
    assign w_diff = {1'b0, w_x} - {1'b0, w_y};

    always_comb begin
        w_alu_res = r_r;
        w_alu_c   = 1'b0;
        case (w_op)
            3'b000:  w_alu_res = w_mod ? r_r : (DW'(0) - w_x);
            3'b001:  begin w_alu_res = w_diff[DW-1:0]; w_alu_c = w_diff[DW]; end
            3'b010:  begin w_alu_res = w_sum[DW-1:0];  w_alu_c = w_sum[DW];  end
            3'b101:  w_alu_res = w_x ^ w_y;
            3'b110:  w_alu_res = w_x & w_y;
            3'b111:  w_alu_res = w_mod ? r_r : ~w_x;
            default: w_alu_res = r_r;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_alu_wr     = 1'b0;
        w_mul_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.reg_en[4]) begin
                    if (w_is_mul) begin
                        w_issue      = 1'b1;
                        w_state_next = S_MUL;
                    end else begin
                        w_alu_wr = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == CW'(DW - 1)) begin
                    w_mul_done   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right so each step tests bit 0 only.
    assign w_acc_next = r_acc + (r_mul_y[0] ? r_mul_x : '0);
    assign w_half     = r_hi_sel ? w_acc_next[2*DW-1:DW] : w_acc_next[DW-1:0];

    always_ff @(posedge clk) begin
        if (sync_reset) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_x0 <= '0; r_x1 <= '0; r_y0 <= '0; r_y1 <= '0;
            r_r  <= '0; r_m  <= '0; r_i  <= '0; r_o_reg <= '0;
            r_z_flag <= 1'b1;
            r_c_flag <= 1'b0;
            r_mul_x  <= '0;
            r_mul_y  <= '0;
            r_acc    <= '0;
            r_hi_sel <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (bus.reg_en[0]) r_x0    <= w_data_bus;
            if (bus.reg_en[1]) r_x1    <= w_data_bus;
            if (bus.reg_en[2]) r_y0    <= w_data_bus;
            if (bus.reg_en[3]) r_y1    <= w_data_bus;
            if (bus.reg_en[5]) r_m     <= w_data_bus;
            if (bus.reg_en[8]) r_o_reg <= w_data_bus;
            if (bus.reg_en[6]) r_i     <= bus.i_sel ? (r_i + r_m) : w_data_bus;

            if (w_alu_wr) begin
                r_r      <= w_alu_res;
                r_z_flag <= (w_alu_res == '0);
                r_c_flag <= w_alu_c;
            end

            if (w_issue) begin
                r_mul_x  <= {{DW{1'b0}}, w_x};
                r_mul_y  <= w_y;
                r_hi_sel <= (w_op == 3'b011);
                r_cnt    <= '0;
                r_acc    <= '0;
            end else if (r_state == S_MUL) begin
                r_acc   <= w_acc_next;
                r_mul_x <= r_mul_x << 1;
                r_mul_y <= r_mul_y >> 1;
                r_cnt   <= r_cnt + CW'(1);
                if (w_mul_done) begin
                    r_r      <= w_half;
                    r_z_flag <= (w_half == '0);
                    r_c_flag <= 1'b0;
                end
            end
        end
    end

    assign bus.data_bus = w_data_bus;
    assign bus.x0       = r_x0;
    assign bus.x1       = r_x1;
    assign bus.y0       = r_y0;
    assign bus.y1       = r_y1;
    assign bus.r        = r_r;
    assign bus.m        = r_m;
    assign bus.i        = r_i;
    assign bus.o_reg    = r_o_reg;
    assign bus.r_eq_0   = r_z_flag;
    assign bus.r_carry  = r_c_flag;
    assign bus.busy     = (r_state == S_MUL);
    assign bus.from_CU  = {r_x1, r_x0};
endmodule

// File: tb/tb_computational_unit_mc.sv
// tb/tb_computational_unit_mc.sv - randomized and directed bench for computational_unit_mc
module tb_computational_unit_mc;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic sync_reset;
    int   n_vec = 0;
    int   n_err = 0;

    computational_unit_mc_if #(.DW(DW)) bus ();
    computational_unit_mc #(.DW(DW)) dut (.clk(clk), .sync_reset(sync_reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.reg_en = '0; bus.source_sel = '0; bus.ir_nibble = '0;
        bus.i_sel = 1'b0; bus.x_sel = 1'b0; bus.y_sel = 1'b0;
        bus.dm = '0; bus.i_pins = '0;
    endtask

    task automatic load(input int idx, input logic [3:0] v);
        bus.source_sel = 4'd8;
        bus.ir_nibble  = v;
        bus.i_sel      = 1'b0;
        bus.reg_en     = 9'(1 << idx);
        tick();
        bus.reg_en = '0;
    endtask

    task automatic alu(input logic [3:0] ir);
        bus.ir_nibble = ir;
        bus.reg_en    = 9'h010;
        tick();
        bus.reg_en = '0;
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (bus.busy && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    function automatic logic [3:0] dut_reg(input int idx);
        case (idx)
            0: return bus.x0;
            1: return bus.x1;
            2: return bus.y0;
            3: return bus.y1;
            5: return bus.m;
            6: return bus.i;
            default: return bus.o_reg;
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] all_regs;
        idle_inputs();
        sync_reset = 1'b1;
        tick(); tick();
        sync_reset = 1'b0;
        all_regs = {bus.x0, bus.x1, bus.y0, bus.y1, bus.r, bus.m, bus.i, bus.o_reg};
        n_vec++;
        if (all_regs !== 32'h0 || bus.r_eq_0 !== 1'b1 || bus.r_carry !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: regs=%h eq0=%b c=%b busy=%b want regs=0 eq0=1 c=0 busy=0",
                     all_regs, bus.r_eq_0, bus.r_carry, bus.busy);
        end
        load(0, 4'd3); load(2, 4'd5);
        alu(4'b0100);
        tick();
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        all_regs = {bus.x0, bus.x1, bus.y0, bus.y1, bus.r, bus.m, bus.i, bus.o_reg};
        n_vec++;
        if (all_regs !== 32'h0 || bus.r_eq_0 !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_mul: regs=%h eq0=%b busy=%b want regs=0 eq0=1 busy=0",
                     all_regs, bus.r_eq_0, bus.busy);
        end
        repeat (6) tick();
        n_vec++;
        if (bus.r !== 4'd0 || bus.busy !== 1'b0 || bus.r_eq_0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_abort: r=%0d busy=%b eq0=%b want r=0 busy=0 eq0=1", bus.r, bus.busy, bus.r_eq_0);
        end
    endtask

    task automatic test_add_sub();
        load(0, 4'd9); load(2, 4'd8);
        alu(4'b0010);
        n_vec++;
        if (bus.r !== 4'd1 || bus.r_carry !== 1'b1 || bus.r_eq_0 !== 1'b0) begin
            n_err++;
            $display("FAIL add_carry: r=%0d c=%b eq0=%b want r=1 c=1 eq0=0", bus.r, bus.r_carry, bus.r_eq_0);
        end
        load(0, 4'd3); load(2, 4'd5);
        alu(4'b0001);
        n_vec++;
        if (bus.r !== 4'd14 || bus.r_carry !== 1'b1 || bus.r_eq_0 !== 1'b0) begin
            n_err++;
            $display("FAIL sub_borrow: r=%0d c=%b eq0=%b want r=14 c=1 eq0=0", bus.r, bus.r_carry, bus.r_eq_0);
        end
    endtask

    task automatic test_mul();
        int cyc;
        load(0, 4'd13); load(2, 4'd11);
        alu(4'b0100);
        wait_idle(20, cyc);
        n_vec++;
        if (cyc !== 4 || bus.r !== 4'd15 || bus.r_carry !== 1'b0 || bus.r_eq_0 !== 1'b0) begin
            n_err++;
            $display("FAIL mul_low: busy_cycles=%0d r=%0d c=%b want busy_cycles=4 r=15 c=0", cyc, bus.r, bus.r_carry);
        end
        alu(4'b0011);
        wait_idle(20, cyc);
        n_vec++;
        if (cyc !== 4 || bus.r !== 4'd8) begin
            n_err++;
            $display("FAIL mul_high: busy_cycles=%0d r=%0d want busy_cycles=4 r=8", cyc, bus.r);
        end
    endtask

    task automatic test_mul_isolation();
        int cyc;
        alu(4'b0100);
        tick();
        load(0, 4'd0);
        alu(4'b0010);
        n_vec++;
        if (bus.r !== 4'd8 || bus.busy !== 1'b1 || bus.x0 !== 4'd0) begin
            n_err++;
            $display("FAIL mul_in_flight: r=%0d busy=%b x0=%0d want r=8 busy=1 x0=0", bus.r, bus.busy, bus.x0);
        end
        wait_idle(20, cyc);
        n_vec++;
        if (bus.r !== 4'd15 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_latched_ops: r=%0d busy=%b want r=15 busy=0", bus.r, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        logic [3:0] r_at_fall;
        int cyc;
        load(0, 4'd5); load(2, 4'd7);
        bus.ir_nibble = 4'b0100;
        bus.reg_en    = 9'h010;
        tick();
        pat[0] = bus.busy;
        r_at_fall = 4'd0;
        for (int k = 1; k < 6; k++) begin
            tick();
            pat[k] = bus.busy;
            if (k == 4) r_at_fall = bus.r;
        end
        bus.reg_en = '0;
        n_vec++;
        if (pat !== 6'b101111 || r_at_fall !== 4'd3) begin
            n_err++;
            $display("FAIL back_to_back: busy_pattern=%b r=%0d want busy_pattern=101111 r=3", pat, r_at_fall);
        end
        wait_idle(20, cyc);
        n_vec++;
        if (bus.r !== 4'd3 || cyc > 4) begin
            n_err++;
            $display("FAIL back_to_back_second: r=%0d wait=%0d want r=3 wait<=4", bus.r, cyc);
        end
    endtask

    task automatic test_index_and_bus();
        load(5, 4'd3); load(6, 4'd14);
        bus.i_sel  = 1'b1;
        bus.reg_en = 9'h040;
        tick();
        bus.reg_en = '0;
        bus.i_sel  = 1'b0;
        n_vec++;
        if (bus.i !== 4'd1) begin
            n_err++;
            $display("FAIL index_wrap: i=%0d want 1", bus.i);
        end
        bus.source_sel = 4'd12;
        #1;
        n_vec++;
        if (bus.data_bus !== 4'd0) begin
            n_err++;
            $display("FAIL bus_unused_src: data_bus=%0d want 0", bus.data_bus);
        end
    endtask

    task automatic test_alu_misc();
        load(0, 4'd2); load(2, 4'd3);
        alu(4'b0010);
        alu(4'b1000);
        n_vec++;
        if (bus.r !== 4'd5 || bus.r_eq_0 !== 1'b0 || bus.r_carry !== 1'b0) begin
            n_err++;
            $display("FAIL nop_hold: r=%0d eq0=%b c=%b want r=5 eq0=0 c=0", bus.r, bus.r_eq_0, bus.r_carry);
        end
        load(0, 4'd0);
        alu(4'b0000);
        n_vec++;
        if (bus.r !== 4'd0 || bus.r_eq_0 !== 1'b1) begin
            n_err++;
            $display("FAIL neg_zero: r=%0d eq0=%b want r=0 eq0=1", bus.r, bus.r_eq_0);
        end
    endtask

    task automatic test_random();
        int mreg [0:8];
        int mr, mz, mc;
        int idx_list [7] = '{0, 1, 2, 3, 5, 6, 8};
        int op_list [6]  = '{0, 1, 2, 5, 6, 7};
        int act, idx, v, op, md, xs, ys, xv, yv, res, c, sel, exp_bus, cyc;
        idle_inputs();
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        for (int k = 0; k < 9; k++) mreg[k] = 0;
        mr = 0; mz = 1; mc = 0;
        for (int n = 0; n < 120; n++) begin
            act = int'($urandom_range(0, 3));
            if (act == 0) begin
                idx = idx_list[$urandom_range(0, 6)];
                v   = int'($urandom_range(0, 15));
                load(idx, 4'(v));
                mreg[idx] = v;
                n_vec++;
                if (dut_reg(idx) !== 4'(v)) begin
                    n_err++;
                    $display("FAIL rand_load reg%0d: got %0d want %0d", idx, dut_reg(idx), v);
                end
            end else if (act == 1 || act == 2) begin
                xs = int'($urandom_range(0, 1));
                ys = int'($urandom_range(0, 1));
                bus.x_sel = xs[0];
                bus.y_sel = ys[0];
                xv = xs ? mreg[1] : mreg[0];
                yv = ys ? mreg[3] : mreg[2];
                md = int'($urandom_range(0, 1));
                if (act == 1) begin
                    op = op_list[$urandom_range(0, 5)];
                    c  = 0;
                    case (op)
                        0: res = md ? mr : (16 - xv) % 16;
                        1: begin res = (xv - yv + 16) % 16; c = (xv < yv) ? 1 : 0; end
                        2: begin res = (xv + yv) % 16; c = (xv + yv > 15) ? 1 : 0; end
                        5: res = xv ^ yv;
                        6: res = xv & yv;
                        default: res = md ? mr : (~xv) & 15;
                    endcase
                    alu(4'(md * 8 + op));
                    cyc = 0;
                end else begin
                    op = md ? 3 : 4;
                    res = md ? (xv * yv) / 16 : (xv * yv) % 16;
                    c = 0;
                    alu(4'(op));
                    wait_idle(20, cyc);
                end
                mr = res; mz = (res == 0) ? 1 : 0; mc = c;
                n_vec++;
                if (bus.r !== 4'(mr) || bus.r_eq_0 !== mz[0] || bus.r_carry !== mc[0] || (act == 2 && cyc != 4)) begin
                    n_err++;
                    $display("FAIL rand_op%0d x=%0d y=%0d: r=%0d eq0=%b c=%b cyc=%0d want r=%0d eq0=%0d c=%0d",
                             op, xv, yv, bus.r, bus.r_eq_0, bus.r_carry, cyc, mr, mz, mc);
                end
                bus.x_sel = 1'b0;
                bus.y_sel = 1'b0;
            end else begin
                sel = int'($urandom_range(0, 15));
                bus.source_sel = 4'(sel);
                bus.dm         = 4'($urandom_range(0, 15));
                bus.i_pins     = 4'($urandom_range(0, 15));
                bus.ir_nibble  = 4'($urandom_range(0, 15));
                #1;
                case (sel)
                    0, 1, 2, 3, 5, 6: exp_bus = mreg[sel];
                    4:       exp_bus = mr;
                    7:       exp_bus = int'(bus.dm);
                    8:       exp_bus = int'(bus.ir_nibble);
                    9:       exp_bus = int'(bus.i_pins);
                    default: exp_bus = 0;
                endcase
                n_vec++;
                if (bus.data_bus !== 4'(exp_bus) || bus.from_CU !== 8'(mreg[1] * 16 + mreg[0])) begin
                    n_err++;
                    $display("FAIL rand_bus sel=%0d: data_bus=%0d from_CU=%h want data_bus=%0d from_CU=%h",
                             sel, bus.data_bus, bus.from_CU, exp_bus, mreg[1] * 16 + mreg[0]);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        sync_reset = 1'b1;
        test_reset();
        test_add_sub();
        test_mul();
        test_mul_isolation();
        test_back_to_back();
        test_index_and_bus();
        test_alu_misc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
